// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared constants, state encodings and byte helper for the memory controller
package mem_ctrl_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 32;
  localparam logic TRUE = 1'b1;
  localparam logic FALSE = 1'b0;
  localparam logic [ADDR_WIDTH-1:0] IO_ADDR_DEF = 32'h30000;
  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;
  typedef enum logic [1:0] {K_STORE, K_IO, K_LOAD, K_FETCH} kind_t;
  function automatic logic [7:0] byte_of(logic [DATA_WIDTH-1:0] d, logic [1:0] i);
    return 8'(d >> {i, 3'b000});
  endfunction
endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: per-port pending latches and fixed-priority grant (store > io > load > fetch)
module mem_arbiter import mem_ctrl_pkg::*; #(
  parameter logic [ADDR_WIDTH-1:0] IO_ADDR = IO_ADDR_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  clear,
  input  logic                  idle,
  input  logic                  if_out_mem,
  input  logic [5:0]            out_mem_size,
  input  logic [ADDR_WIDTH-1:0] out_mem_addr,
  input  logic [DATA_WIDTH-1:0] out_mem_data,
  input  logic                  if_out_mem_io,
  input  logic                  if_load_lsb,
  input  logic [ADDR_WIDTH-1:0] load_addr_lsb,
  input  logic [2:0]            load_size_lsb,
  input  logic                  if_fetch,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic                  grant,
  output kind_t                 grant_kind,
  output logic [ADDR_WIDTH-1:0] grant_addr,
  output logic [DATA_WIDTH-1:0] grant_data,
  output logic [2:0]            grant_n
);
  logic st_p, io_p, ld_p, fe_p;
  logic [ADDR_WIDTH-1:0] st_addr, ld_addr, fe_addr;
  logic [DATA_WIDTH-1:0] st_data;
  logic [2:0] st_n, ld_n;
  // a flush blocks read grants in its own cycle; committed stores still go
  assign grant = rdy && idle && (st_p || (!clear && (io_p || ld_p || fe_p)));
  assign grant_data = st_data;
  always_comb begin
    grant_kind = st_p ? K_STORE : io_p ? K_IO : ld_p ? K_LOAD : K_FETCH;
    grant_addr = st_p ? st_addr : io_p ? IO_ADDR : ld_p ? ld_addr : fe_addr;
    grant_n = st_p ? st_n : io_p ? 3'd1 : ld_p ? ld_n : 3'd4;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st_p <= FALSE;
      io_p <= FALSE;
      ld_p <= FALSE;
      fe_p <= FALSE;
      st_addr <= '0;
      st_data <= '0;
      st_n <= '0;
      ld_addr <= '0;
      ld_n <= '0;
      fe_addr <= '0;
    end else if (rdy) begin
      if (grant && grant_kind == K_STORE) st_p <= FALSE;
      if (if_out_mem && !st_p) begin
        st_p <= TRUE;
        st_addr <= out_mem_addr;
        st_data <= out_mem_data;
        st_n <= |out_mem_size[5:3] ? 3'd4 : out_mem_size[2:0];
      end
      if (clear || (grant && grant_kind == K_IO)) io_p <= FALSE;
      else if (if_out_mem_io) io_p <= TRUE;
      if (clear || (grant && grant_kind == K_LOAD)) ld_p <= FALSE;
      else if (if_load_lsb && !ld_p) begin
        ld_p <= TRUE;
        ld_addr <= load_addr_lsb;
        ld_n <= load_size_lsb;
      end
      if (clear || (grant && grant_kind == K_FETCH)) fe_p <= FALSE;
      else if (if_fetch && !fe_p) begin
        fe_p <= TRUE;
        fe_addr <= fetch_addr;
      end
    end
  end
endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial RAM sequencer serving store, I/O read, load and fetch ports
module mem_ctrl import mem_ctrl_pkg::*; #(
  parameter logic [ADDR_WIDTH-1:0] IO_ADDR = IO_ADDR_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  clear,
  input  logic                  if_out_mem,
  input  logic [5:0]            out_mem_size,
  input  logic [ADDR_WIDTH-1:0] out_mem_addr,
  input  logic [DATA_WIDTH-1:0] out_mem_data,
  output logic                  if_stored,
  input  logic                  if_out_mem_io,
  output logic                  if_get_mem,
  output logic [DATA_WIDTH-1:0] data_mem,
  input  logic                  if_load_lsb,
  input  logic [ADDR_WIDTH-1:0] load_addr_lsb,
  input  logic [2:0]            load_size_lsb,
  output logic                  if_loaded,
  output logic [DATA_WIDTH-1:0] data_to_lsb,
  input  logic                  if_fetch,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic                  if_fetched,
  output logic [DATA_WIDTH-1:0] inst_to_if,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_wr,
  input  logic                  io_buffer_full
);
  state_t state;
  kind_t op_kind, grant_kind;
  logic grant, wr, stall;
  logic [ADDR_WIDTH-1:0] op_addr, grant_addr;
  logic [DATA_WIDTH-1:0] op_data, grant_data, rbuf, rnext;
  logic [2:0] op_n, grant_n, cnt, cnt1, cntm1;
  mem_arbiter #(.IO_ADDR(IO_ADDR)) arb (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear), .idle(state == IDLE),
    .if_out_mem(if_out_mem), .out_mem_size(out_mem_size),
    .out_mem_addr(out_mem_addr), .out_mem_data(out_mem_data),
    .if_out_mem_io(if_out_mem_io), .if_load_lsb(if_load_lsb),
    .load_addr_lsb(load_addr_lsb), .load_size_lsb(load_size_lsb),
    .if_fetch(if_fetch), .fetch_addr(fetch_addr),
    .grant(grant), .grant_kind(grant_kind), .grant_addr(grant_addr),
    .grant_data(grant_data), .grant_n(grant_n)
  );
  assign cnt1 = cnt + 3'd1;
  assign cntm1 = cnt - 3'd1;
  // RAM returns byte cnt-1 one cycle after its address was presented
  assign rnext = rbuf | (DATA_WIDTH'(mem_din) << {cntm1, 3'b000});
  assign stall = wr && mem_a == IO_ADDR && io_buffer_full;
  assign mem_wr = wr && rdy && !stall;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      op_kind <= K_STORE;
      op_addr <= '0;
      op_data <= '0;
      op_n <= '0;
      cnt <= '0;
      rbuf <= '0;
      wr <= FALSE;
      mem_a <= '0;
      mem_dout <= '0;
      if_stored <= FALSE;
      if_get_mem <= FALSE;
      if_loaded <= FALSE;
      if_fetched <= FALSE;
      data_mem <= '0;
      data_to_lsb <= '0;
      inst_to_if <= '0;
    end else if (rdy) begin
      if_stored <= FALSE;
      if_get_mem <= FALSE;
      if_loaded <= FALSE;
      if_fetched <= FALSE;
      case (state)
        IDLE: if (grant) begin
          state <= grant_kind == K_STORE ? WRITE : READ;
          op_kind <= grant_kind;
          op_addr <= grant_addr;
          op_data <= grant_data;
          op_n <= grant_n;
          cnt <= '0;
          rbuf <= '0;
          wr <= grant_kind == K_STORE;
          mem_a <= grant_addr;
          mem_dout <= grant_kind == K_STORE ? grant_data[7:0] : 8'h00;
        end
        WRITE: if (!stall) begin
          if (cnt1 == op_n) begin
            state <= IDLE;
            wr <= FALSE;
            mem_a <= '0;
            mem_dout <= '0;
            if_stored <= TRUE;
          end else begin
            cnt <= cnt1;
            mem_a <= op_addr + ADDR_WIDTH'(cnt1);
            mem_dout <= byte_of(op_data, cnt1[1:0]);
          end
        end
        READ: if (clear) begin
          state <= IDLE;
          mem_a <= '0;
        end else begin
          if (cnt != 3'd0) rbuf <= rnext;
          if (cnt == op_n) begin
            state <= IDLE;
            if_get_mem <= op_kind == K_IO;
            if_loaded <= op_kind == K_LOAD;
            if_fetched <= op_kind == K_FETCH;
            if (op_kind == K_IO) data_mem <= rnext;
            if (op_kind == K_LOAD) data_to_lsb <= rnext;
            if (op_kind == K_FETCH) inst_to_if <= rnext;
          end else begin
            cnt <= cnt1;
            mem_a <= cnt1 == op_n ? '0 : op_addr + ADDR_WIDTH'(cnt1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed scenarios checked per cycle against a transaction-level schedule model
module tb_mem_ctrl;
  localparam logic [31:0] IOA = 32'h30000;
  localparam int NC = 1024;
  logic clk = 0, rst = 1, rdy = 1, clear = 0, io_buffer_full = 0;
  logic if_out_mem = 0, if_out_mem_io = 0, if_load_lsb = 0, if_fetch = 0;
  logic [5:0] out_mem_size = 0;
  logic [31:0] out_mem_addr = 0, out_mem_data = 0, load_addr_lsb = 0, fetch_addr = 0;
  logic [2:0] load_size_lsb = 0;
  logic if_stored, if_get_mem, if_loaded, if_fetched, mem_wr;
  logic [31:0] data_mem, data_to_lsb, inst_to_if, mem_a;
  logic [7:0] mem_dout, mem_din, io_in, io_out;
  logic [7:0] ram [4096];
  int cyc = 0, n_tests = 0, n_fail = 0, free_at = 0;
  bit chk_en = 0;
  logic exp_wr [NC];
  bit exp_dc [NC];
  logic [31:0] exp_a [NC], exp_dat [NC];
  logic [7:0] exp_dout [NC];
  logic [3:0] exp_done [NC];
  logic [7:0] mram [4096];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_ctrl #(.IO_ADDR(IOA)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
    .if_out_mem(if_out_mem), .out_mem_size(out_mem_size), .out_mem_addr(out_mem_addr),
    .out_mem_data(out_mem_data), .if_stored(if_stored),
    .if_out_mem_io(if_out_mem_io), .if_get_mem(if_get_mem), .data_mem(data_mem),
    .if_load_lsb(if_load_lsb), .load_addr_lsb(load_addr_lsb), .load_size_lsb(load_size_lsb),
    .if_loaded(if_loaded), .data_to_lsb(data_to_lsb),
    .if_fetch(if_fetch), .fetch_addr(fetch_addr), .if_fetched(if_fetched), .inst_to_if(inst_to_if),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  function automatic logic [7:0] init_byte(int i);
    return i == 0 ? 8'h13 : i == 1 ? 8'h05 : i < 4 ? 8'h00 : 8'(i * 7 + 3);
  endfunction

  // RAM with one-cycle read latency; paused together with the core when rdy is low
  always @(posedge clk)
    if (rst) begin
      for (int i = 0; i < 4096; i++) ram[i] <= init_byte(i);
      mem_din <= 8'h00;
    end else if (rdy) begin
      if (mem_wr && mem_a == IOA) io_out <= mem_dout;
      else if (mem_wr) ram[mem_a[11:0]] <= mem_dout;
      mem_din <= mem_a == IOA ? io_in : ram[mem_a[11:0]];
    end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 4096; i++) mram[i] = init_byte(i);
    for (int i = 0; i < NC; i++) begin
      exp_wr[i] = 0; exp_dc[i] = 0; exp_a[i] = 0; exp_dat[i] = 0; exp_dout[i] = 0; exp_done[i] = 0;
    end
  endfunction

  function automatic logic [7:0] model_byte(logic [31:0] a);
    return a == IOA ? io_in : mram[a[11:0]];
  endfunction

  // one free cycle in IDLE to grant, then the operation starts
  function automatic int start_of(int t);
    return ((t + 1 > free_at) ? t + 1 : free_at) + 1;
  endfunction

  function automatic void sched_write(int s, logic [31:0] a, logic [31:0] d, int n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] x;
      x = a + 32'(i);
      exp_wr[s + i] = 1;
      exp_a[s + i] = x;
      exp_dout[s + i] = d[8 * i +: 8];
      mram[x[11:0]] = d[8 * i +: 8];
    end
    exp_done[s + n][0] = 1;
    free_at = s + n;
  endfunction

  // port: 1 io, 2 load, 3 fetch; abort = cycle clear is asserted (0 = none)
  function automatic void sched_read(int s, logic [31:0] a, int n, int port, int abort);
    logic [31:0] v = 0;
    for (int i = 0; i < n; i++) begin
      if (abort == 0 || s + i <= abort) exp_a[s + i] = a + 32'(i);
      v[8 * i +: 8] = model_byte(a + 32'(i));
    end
    if (abort == 0) begin
      exp_dc[s + n] = 1;
      exp_done[s + n + 1][port] = 1;
      exp_dat[s + n + 1] = v;
      free_at = s + n + 1;
    end else free_at = abort + 1;
  endfunction

  always @(negedge clk)
    if (chk_en && cyc < NC) begin
      check("bus_wr", 32'(mem_wr), 32'(exp_wr[cyc]));
      if (!exp_dc[cyc]) check("bus_a", mem_a, exp_a[cyc]);
      check("bus_dout", 32'(mem_dout), 32'(exp_dout[cyc]));
      check("done", 32'({if_fetched, if_loaded, if_get_mem, if_stored}), 32'(exp_done[cyc]));
      if (exp_done[cyc][1]) check("data_mem", data_mem, exp_dat[cyc]);
      if (exp_done[cyc][2]) check("data_to_lsb", data_to_lsb, exp_dat[cyc]);
      if (exp_done[cyc][3]) check("inst_to_if", inst_to_if, exp_dat[cyc]);
    end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic drop();
    if_out_mem = 0; if_out_mem_io = 0; if_load_lsb = 0; if_fetch = 0;
  endtask

  initial begin
    int t, s;
    logic bad;
    io_in = 8'h41;
    model_reset();
    repeat (3) tick();
    check("rst_mem_wr", 32'(mem_wr), 0);
    check("rst_mem_a", mem_a, 0);
    check("rst_mem_dout", 32'(mem_dout), 0);
    check("rst_dones", 32'({if_fetched, if_loaded, if_get_mem, if_stored}), 0);
    check("rst_data", data_mem | data_to_lsb | inst_to_if, 0);
    rst = 0;
    tick();
    free_at = cyc;
    chk_en = 1;

    // SW 0x100
    t = cyc;
    out_mem_size = 4; out_mem_addr = 32'h100; out_mem_data = 32'hAABBCCDD; if_out_mem = 1;
    sched_write(start_of(t), 32'h100, 32'hAABBCCDD, 4);
    tick(); drop();
    idle_until(free_at + 2);
    check("sw_ram", {ram[12'h103], ram[12'h102], ram[12'h101], ram[12'h100]}, 32'hAABBCCDD);

    // fetch 0x0
    t = cyc;
    fetch_addr = 32'h0; if_fetch = 1;
    sched_read(start_of(t), 32'h0, 4, 3, 0);
    tick(); drop();
    idle_until(t + 7);
    check("fetch_pulse_s5", 32'(if_fetched), 1);
    check("fetch_inst", inst_to_if, 32'h00000513);
    idle_until(free_at + 2);

    // store (SH with address wrap), load and fetch in one cycle
    t = cyc;
    out_mem_size = 2; out_mem_addr = 32'hFFFFFFFF; out_mem_data = 32'h00001234; if_out_mem = 1;
    load_addr_lsb = 32'hFFFFFFFF; load_size_lsb = 2; if_load_lsb = 1;
    fetch_addr = 32'h10; if_fetch = 1;
    sched_write(start_of(t), 32'hFFFFFFFF, 32'h00001234, 2);
    sched_read(start_of(t), 32'hFFFFFFFF, 2, 2, 0);
    sched_read(start_of(t), 32'h10, 4, 3, 0);
    tick(); drop();
    idle_until(free_at + 2);
    check("wrap_load", data_to_lsb, 32'h00001234);
    check("fetch_0x10", inst_to_if, 32'h88817A73);

    // LH 0x200 aborted by clear at S+1, then a clean fetch
    t = cyc;
    load_addr_lsb = 32'h200; load_size_lsb = 2; if_load_lsb = 1;
    s = start_of(t);
    sched_read(s, 32'h200, 2, 2, s + 1);
    tick(); drop();
    idle_until(s + 1);
    clear = 1;
    tick();
    clear = 0;
    t = cyc;
    fetch_addr = 32'h4; if_fetch = 1;
    sched_read(start_of(t), 32'h4, 4, 3, 0);
    tick(); drop();
    idle_until(free_at + 2);
    check("clr_no_load", data_to_lsb, 32'h00001234);

    // clear together with store and load pulses: only the store survives
    t = cyc;
    out_mem_size = 1; out_mem_addr = 32'h300; out_mem_data = 32'h0000005A; if_out_mem = 1;
    load_addr_lsb = 32'h100; load_size_lsb = 1; if_load_lsb = 1; clear = 1;
    sched_write(start_of(t), 32'h300, 32'h5A, 1);
    tick(); drop(); clear = 0;
    idle_until(free_at + 2);
    check("clr_store_ram", 32'(ram[12'h300]), 32'h5A);

    // second load pulse while the first is still pending is ignored
    t = cyc;
    load_addr_lsb = 32'h101; load_size_lsb = 1; if_load_lsb = 1;
    sched_read(start_of(t), 32'h101, 1, 2, 0);
    tick();
    load_addr_lsb = 32'h102;
    tick(); drop();
    idle_until(free_at + 2);
    check("dup_load", data_to_lsb, 32'h000000CC);

    // I/O read
    t = cyc;
    if_out_mem_io = 1;
    s = start_of(t);
    sched_read(s, IOA, 1, 1, 0);
    tick(); drop();
    idle_until(s + 2);
    check("io_pulse_s2", 32'(if_get_mem), 1);
    check("io_data", data_mem, 32'h00000041);
    idle_until(free_at + 3);
    check("io_hold", data_mem, 32'h00000041);

    // SB to IO_ADDR while the I/O buffer is full for three cycles
    chk_en = 0;
    io_buffer_full = 1;
    out_mem_size = 1; out_mem_addr = IOA; out_mem_data = 32'h37; if_out_mem = 1;
    tick(); drop();
    tick();
    for (int i = 0; i < 3; i++) begin
      check("full_no_wr", 32'(mem_wr), 0);
      check("full_hold_a", mem_a, IOA);
      tick();
    end
    io_buffer_full = 0;
    #1;
    check("full_drop_wr", 32'(mem_wr), 1);
    check("full_drop_dout", 32'(mem_dout), 32'h37);
    tick();
    check("full_stored", 32'(if_stored), 1);
    check("io_out", 32'(io_out), 32'h37);
    tick();

    // I/O read with rdy low for one cycle mid-read
    io_in = 8'h42;
    if_out_mem_io = 1;
    tick(); drop();
    tick();
    check("rdy_io_a", mem_a, IOA);
    tick();
    check("rdy_pre", 32'(if_get_mem), 0);
    rdy = 0;
    #1;
    check("rdy_low_wr", 32'(mem_wr), 0);
    tick();
    rdy = 1;
    check("rdy_late", 32'(if_get_mem), 0);
    tick();
    check("rdy_pulse_s3", 32'(if_get_mem), 1);
    check("rdy_data", data_mem, 32'h00000042);
    tick();

    // reset in the middle of a WRITE
    out_mem_size = 4; out_mem_addr = 32'h400; out_mem_data = 32'h11223344; if_out_mem = 1;
    tick(); drop();
    tick();
    check("rstw_start", 32'(mem_wr), 1);
    tick();
    rst = 1;
    tick();
    rst = 0;
    check("rstw_wr", 32'(mem_wr), 0);
    check("rstw_a", mem_a, 0);
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      bad = bad | if_stored | mem_wr | (mem_a != 0);
      tick();
    end
    check("rstw_quiet", 32'(bad), 0);

    // clean fetch after reset
    model_reset();
    free_at = cyc;
    chk_en = 1;
    t = cyc;
    fetch_addr = 32'h0; if_fetch = 1;
    sched_read(start_of(t), 32'h0, 4, 3, 0);
    tick(); drop();
    idle_until(free_at + 2);
    check("final_fetch", inst_to_if, 32'h00000513);
    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
